// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: processor has priority, peripheral DMA uses idle cycles,
// with a one-cycle forced processor stall on starvation. ARB_STATS_EN adds grant/stall counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_wren,
    input  logic              cpu_rden,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_rdata,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataIn,
`ifdef ARB_STATS_EN
    output logic [15:0]       per_grant_count,
    output logic [15:0]       stall_count,
`endif
    input  logic [DATA_W-1:0] mem_dataOut
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                per_rvalid_q, per_rvalid_d;
    logic [DATA_W-1:0]   per_rdata_q, per_rdata_d;
    logic                cpu_act;

    // Ownership of the RAM port and starvation tracking
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cpu_stall    = 1'b0;
        per_gnt      = 1'b0;
        mem_wEn      = 1'b0;
        mem_addr     = cpu_addr;
        mem_dataIn   = cpu_data;
        cpu_act      = cpu_wren | cpu_rden;

        case (state_q)
            ST_ARB: begin
                if (cpu_act) begin
                    mem_wEn = cpu_wren;
                end else if (per_req) begin
                    per_gnt    = 1'b1;
                    mem_wEn    = per_we;
                    mem_addr   = per_addr;
                    mem_dataIn = per_wdata;
                end
                if (per_req && !per_gnt) begin
                    starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                                           : starve_cnt_q + CNT_W'(1);
                    if (starve_cnt_d == LIMIT) begin
                        state_d = ST_FORCE;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_FORCE: begin
                // Processor op is dropped; it re-presents it next cycle
                cpu_stall    = 1'b1;
                per_gnt      = per_req;
                mem_wEn      = per_req & per_we;
                mem_addr     = per_addr;
                mem_dataIn   = per_wdata;
                starve_cnt_d = '0;
                state_d      = ST_ARB;
            end
            default: begin
                state_d      = ST_ARB;
                starve_cnt_d = '0;
            end
        endcase
    end

    // Read data comes straight from the RAM's output register in the valid cycle, then is held
    always_comb begin
        per_rvalid   = per_rvalid_q & ~reset;
        per_rdata    = per_rvalid ? mem_dataOut : per_rdata_q;
        per_rvalid_d = per_gnt & ~per_we;
        per_rdata_d  = per_rdata;
        cpu_q        = mem_dataOut;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_ARB;
            starve_cnt_q <= '0;
            per_rvalid_q <= 1'b0;
            per_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            per_rvalid_q <= per_rvalid_d;
            per_rdata_q  <= per_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (per_gnt && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
        if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        per_grant_count = grant_cnt_q;
        stall_count     = stall_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
